// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the bit serializer: FSM state encoding and
// default word geometry.
package bit_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH     = 8;
    localparam bit DEFAULT_MSB_FIRST = 1'b1;

endpackage

// File: rtl/serial_shift_reg.sv
// Shift register and remaining-bit counter for the serializer; drives the
// registered serial outputs under control of the parent FSM.
module serial_shift_reg
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = DEFAULT_MSB_FIRST
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             advance,
    input  logic [WIDTH-1:0] load_data,
    output logic             count_zero,
    output logic             x,
    output logic             x_valid,
    output logic             x_last
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    count;

    // The first bit goes straight to x on load, so sreg only ever holds the
    // bits still to come, already aligned to the emitting end.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sreg    <= '0;
            count   <= '0;
            x       <= 1'b0;
            x_valid <= 1'b0;
            x_last  <= 1'b0;
        end else if (load) begin
            count   <= CW'(WIDTH - 1);
            x_valid <= 1'b1;
            x_last  <= 1'b0;
            if (MSB_FIRST) begin
                x    <= load_data[WIDTH-1];
                sreg <= load_data << 1;
            end else begin
                x    <= load_data[0];
                sreg <= load_data >> 1;
            end
        end else if (advance && !count_zero) begin
            count   <= count - CW'(1);
            x_valid <= 1'b1;
            x_last  <= (count == CW'(1));
            if (MSB_FIRST) begin
                x    <= sreg[WIDTH-1];
                sreg <= sreg << 1;
            end else begin
                x    <= sreg[0];
                sreg <= sreg >> 1;
            end
        end else begin
            count   <= '0;
            x       <= 1'b0;
            x_valid <= 1'b0;
            x_last  <= 1'b0;
        end
    end

    assign count_zero = (count == '0);

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a valid/ready load port and a registered
// serial stream that supports gap-free back-to-back words.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = DEFAULT_MSB_FIRST
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             x,
    output logic             x_valid,
    output logic             x_last
);

    state_t state;
    state_t next_state;
    logic   count_zero;
    logic   advance;
    logic   handshake;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Ready reopens during the final bit so a waiting word follows with no gap.
    always_comb begin
        next_state = state;
        load_ready = 1'b0;
        advance    = 1'b0;
        case (state)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                load_ready = count_zero;
                advance    = !count_zero;
                if (count_zero && !load_valid) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign handshake = load_valid && load_ready;

    serial_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk        (clk),
        .reset      (reset),
        .load       (handshake),
        .advance    (advance),
        .load_data  (load_data),
        .count_zero (count_zero),
        .x          (x),
        .x_valid    (x_valid),
        .x_last     (x_last)
    );

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: MSB-first and LSB-first instances share one
// load port; every emitted bit is checked against a scoreboard queue.
module tb_bit_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic       loadValid;
    logic [7:0] loadData;

    logic mReady, mX, mXValid, mXLast;
    logic lReady, lX, lXValid, lXLast;

    int checks = 0;
    int errors = 0;

    logic [1:0] qm[$];
    logic [1:0] ql[$];
    logic [1:0] expM;
    logic [1:0] expL;

    typedef struct {
        logic [7:0] data;
        logic [7:0] streamMsb;
        logic [7:0] streamLsb;
    } vector_t;

    vector_t vectors[6];

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dutMsb (
        .clk        (clk),
        .reset      (reset),
        .load_valid (loadValid),
        .load_data  (loadData),
        .load_ready (mReady),
        .x          (mX),
        .x_valid    (mXValid),
        .x_last     (mXLast)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dutLsb (
        .clk        (clk),
        .reset      (reset),
        .load_valid (loadValid),
        .load_data  (loadData),
        .load_ready (lReady),
        .x          (lX),
        .x_valid    (lXValid),
        .x_last     (lXLast)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stream words are written first-emitted bit at index 7.
    task automatic applyStimulus(input logic [7:0] d, input logic [7:0] sm,
                                 input logic [7:0] sl, input bit keep);
        bit done = 1'b0;
        loadValid = 1'b1;
        loadData  = d;
        for (int c = 0; c < 40 && !done; c++) begin
            if (mReady) begin
                for (int i = 7; i >= 0; i--) begin
                    qm.push_back({sm[i], i == 0});
                    ql.push_back({sl[i], i == 0});
                end
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        checkOutput("handshake_accepted", done, 1);
        if (!keep) begin
            loadValid = 1'b0;
        end
    endtask

    task automatic drainWait();
        for (int c = 0; c < 60 && (qm.size() != 0 || ql.size() != 0); c++) begin
            @(negedge clk);
        end
        checkOutput("drain_empty", qm.size() + ql.size(), 0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (mXValid) begin
                if (qm.size() == 0) begin
                    checkOutput("msb_unexpected_bit", 1, 0);
                end else begin
                    expM = qm.pop_front();
                    checkOutput("msb_x", mX, expM[1]);
                    checkOutput("msb_last", mXLast, expM[0]);
                end
            end else begin
                checkOutput("msb_idle_outputs", {mX, mXLast}, 0);
            end
            if (lXValid) begin
                if (ql.size() == 0) begin
                    checkOutput("lsb_unexpected_bit", 1, 0);
                end else begin
                    expL = ql.pop_front();
                    checkOutput("lsb_x", lX, expL[1]);
                    checkOutput("lsb_last", lXLast, expL[0]);
                end
            end else begin
                checkOutput("lsb_idle_outputs", {lX, lXLast}, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vectors[0] = '{8'hA5, 8'hA5, 8'hA5};
        vectors[1] = '{8'h01, 8'h01, 8'h80};
        vectors[2] = '{8'hC3, 8'hC3, 8'hC3};
        vectors[3] = '{8'hF0, 8'hF0, 8'h0F};
        vectors[4] = '{8'h3A, 8'h3A, 8'h5C};
        vectors[5] = '{8'hFF, 8'hFF, 8'hFF};

        reset     = 1'b0;
        loadValid = 1'b0;
        loadData  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ready", mReady, 1);
        checkOutput("reset_xvalid", mXValid, 0);
        checkOutput("reset_x", mX, 0);
        checkOutput("reset_xlast", mXLast, 0);
        checkOutput("reset_ready_lsb", lReady, 1);

        // A handshake presented while reset is low must be discarded.
        loadValid = 1'b1;
        loadData  = 8'hFF;
        @(posedge clk);
        #1;
        loadValid = 1'b0;
        reset     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_handshake_dropped", mXValid, 0);

        foreach (vectors[v]) begin
            applyStimulus(vectors[v].data, vectors[v].streamMsb, vectors[v].streamLsb, 1'b0);
            drainWait();
            checkOutput("idle_ready", mReady, 1);
            checkOutput("idle_ready_lsb", lReady, 1);
            checkOutput("idle_xvalid", mXValid, 0);
        end

        // Ready profile across a single word: low for bits 1-7, high on bit 8.
        applyStimulus(8'hA5, 8'hA5, 8'hA5, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            checkOutput("busy_ready", mReady, k == 8);
            @(posedge clk);
            #1;
        end
        drainWait();

        // Back-to-back FF then 00 with load_valid held: 16 contiguous bits.
        loadValid = 1'b1;
        loadData  = 8'hFF;
        for (int i = 7; i >= 0; i--) begin
            qm.push_back({1'b1, i == 0});
            ql.push_back({1'b1, i == 0});
        end
        for (int i = 7; i >= 0; i--) begin
            qm.push_back({1'b0, i == 0});
            ql.push_back({1'b0, i == 0});
        end
        @(posedge clk);
        #1;
        loadData = 8'h00;
        for (int k = 1; k <= 16; k++) begin
            checkOutput("b2b_xvalid", mXValid, 1);
            checkOutput("b2b_xlast", mXLast, (k == 8) || (k == 16));
            @(posedge clk);
            #1;
            if (k == 8) begin
                loadValid = 1'b0;
            end
        end
        checkOutput("b2b_done_xvalid", mXValid, 0);
        drainWait();

        // Word offered while busy is only taken at the last bit.
        applyStimulus(8'hF0, 8'hF0, 8'h0F, 1'b1);
        applyStimulus(8'h0F, 8'h0F, 8'hF0, 1'b0);
        drainWait();

        // Reset mid-word after three bits of C3 aborts the word.
        applyStimulus(8'hC3, 8'hC3, 8'hC3, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        qm.delete();
        ql.delete();
        reset = 1'b1;
        checkOutput("midreset_x", mX, 0);
        checkOutput("midreset_xvalid", mXValid, 0);
        checkOutput("midreset_xlast", mXLast, 0);
        checkOutput("midreset_ready", mReady, 1);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("midreset_no_residue", mXValid | lXValid, 0);

        drainWait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, setting the parallel word width in bits (legal values 2..32).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 first, 0 = bit 0 first.
REQ-003 The block SHALL have one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-low reset; sampled only at the rising edge of clk.
REQ-006 load_valid  input  1  upstream asserts when load_data holds a word to send.
REQ-007 load_data  input  WIDTH  parallel word; captured only on handshake.
REQ-008 load_ready  output  1  block can accept a word this cycle.
REQ-009 x  output  1  serial data bit, registered; feeds the downstream sequence detector's x input.
REQ-010 x_valid  output  1  x carries a word bit this cycle, registered.
REQ-011 x_last  output  1  high with the final bit of each word, registered.

Function
REQ-012 A handshake SHALL occur at a rising edge where load_valid=1, load_ready=1 and reset=1; only then is load_data captured.
REQ-013 The FSM SHALL have exactly two states: IDLE and SHIFT.
REQ-014 IDLE: load_ready=1; on handshake go to SHIFT, else stay.
REQ-015 SHIFT: load_ready=1 only while the remaining-bit count is 0, i.e. during the last bit; otherwise 0.
REQ-016 At the handshake edge, x SHALL take the first bit, x_valid=1, and the count SHALL load WIDTH-1; latency is one edge.
REQ-017 Each later edge in SHIFT SHALL present the next bit in the MSB_FIRST order and decrement the count.
REQ-018 x_last SHALL be 1 exactly in the cycle the count is 0 and x_valid=1.
REQ-019 At the last-bit edge with handshake, the new word's first bit SHALL follow with no gap (back-to-back streaming), remaining in SHIFT.
REQ-020 At the last-bit edge without handshake, the block SHALL go to IDLE with x=0, x_valid=0, x_last=0.
REQ-021 load_valid while load_ready=0 SHALL be ignored with no effect on state or data.
REQ-022 x SHALL be 0 whenever x_valid=0.
REQ-023 The count SHALL be $clog2(WIDTH) bits wide and never wrap below 0.

Reset
REQ-024 With reset=0 at an edge: state=IDLE, x=0, x_valid=0, x_last=0, count=0, shift register=0.
REQ-025 load_ready SHALL read 1 in the cycle after reset is applied.
REQ-026 A reset mid-word SHALL abort the word; no residual bits SHALL appear after reset is released.
REQ-027 A handshake coinciding with reset=0 SHALL be discarded.

Structure
REQ-028 The state encodings (IDLE=0, SHIFT=1) and the WIDTH/MSB_FIRST default constants SHALL live in shared package bit_serializer_pkg.
REQ-029 The shift register and bit counter SHALL be one sub-module, serial_shift_reg; the FSM and handshake logic stay in bit_serializer.

Verification
REQ-030 WIDTH=8, MSB_FIRST=1, load 8'hA5 once: x=1,0,1,0,0,1,0,1 on 8 consecutive cycles with x_valid=1; x_last only on the 8th; load_ready=0 for cycles 1-7.
REQ-031 MSB_FIRST=0, load 8'h01: x=1 then seven 0s; x_valid then drops to 0 and load_ready returns to 1.
REQ-032 Back-to-back 8'hFF then 8'h00 (load_valid held): 16 contiguous x_valid cycles, x=eight 1s then eight 0s, x_last on cycles 8 and 16.
REQ-033 load 8'hF0, hold load_valid=1 with load_data=8'h0F during bits 2-6: no capture; after the last bit, the next word is 8'h0F.
REQ-034 Reset=0 for one edge after 3 bits of 8'hC3: next cycle x=0, x_valid=0, x_last=0, load_ready=1; no further bits.
REQ-035 Integration: serializer drives the downstream detector's x; the stream 8'hFF followed by reset release produces that detector's documented y response.
